// File: rtl/fwd_hazard_unit.sv
// +--------------------------------------------------------------------------+
// | fwd_hazard_unit : EX/MEM/WB write tracking, operand forwarding and        |
// |                   load-use stall. Optional stats counters: FWD_STATS_EN.  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module fwd_hazard_unit #(
   parameter int NBITS   = 32,
   parameter int REGBITS = 5,
   parameter int NPORTS  = 2,
   parameter int SELBITS = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_id_valid,
   input  logic [REGBITS-1:0]         i_id_rd,
   input  logic                       i_id_wr,
   input  logic                       i_id_load,
   input  logic [NPORTS*REGBITS-1:0]  i_id_rs,
   input  logic [NPORTS*NBITS-1:0]    i_regbnk,
   input  logic [NBITS-1:0]           i_alu_data,
   input  logic [NBITS-1:0]           i_mem_data,
   input  logic [NBITS-1:0]           i_wb_data,
   input  logic                       i_flush,
   output logic [NPORTS*SELBITS-1:0]  o_sel,
   output logic [NPORTS*NBITS-1:0]    o_fwd_data,
`ifdef FWD_STATS_EN
   output logic [31:0]                o_stall_cnt,
   output logic [31:0]                o_fwd_cnt,
`endif
   output logic                       o_stall
);

   localparam logic [SELBITS-1:0] c_SEL_REGBNK = 2'b00;
   localparam logic [SELBITS-1:0] c_SEL_EX     = 2'b01;
   localparam logic [SELBITS-1:0] c_SEL_MEM    = 2'b10;
   localparam logic [SELBITS-1:0] c_SEL_WB     = 2'b11;

   logic               ex_vld_q,  mem_vld_q, wb_vld_q;
   logic [REGBITS-1:0] ex_rd_q,   mem_rd_q,  wb_rd_q;
   logic               ex_ld_q,   mem_ld_q;
   logic               ex_vld_d;
   logic [NPORTS-1:0]  w_lu;

   // A port whose producer is a load still in EX must wait; it reads the bank meanwhile.
   for (genvar p = 0; p < NPORTS; p++) begin : g_port
      logic [REGBITS-1:0] rs;
      logic               nz;
      logic               hit_ex;
      logic               hit_mem;
      logic               hit_wb;
      logic [SELBITS-1:0] sel;
      logic [NBITS-1:0]   data;

      assign rs      = i_id_rs[p*REGBITS +: REGBITS];
      assign nz      = |rs;
      assign hit_ex  = nz & ex_vld_q  & (ex_rd_q  == rs);
      assign hit_mem = nz & mem_vld_q & (mem_rd_q == rs);
      assign hit_wb  = nz & wb_vld_q  & (wb_rd_q  == rs);
      assign w_lu[p] = hit_ex & ex_ld_q;

      always_comb begin
         sel = c_SEL_REGBNK;
         if (hit_ex)
            sel = ex_ld_q ? c_SEL_REGBNK : c_SEL_EX;
         else if (hit_mem)
            sel = c_SEL_MEM;
         else if (hit_wb)
            sel = c_SEL_WB;
      end

      always_comb begin
         case (sel)
            c_SEL_REGBNK: data = i_regbnk[p*NBITS +: NBITS];
            c_SEL_EX:     data = i_alu_data;
            c_SEL_MEM:    data = i_mem_data;
            default:      data = i_wb_data;
         endcase
      end

      assign o_sel[p*SELBITS +: SELBITS]  = sel;
      assign o_fwd_data[p*NBITS +: NBITS] = data;
   end

   // A taken branch kills the decode slot, so it never needs to be held.
   assign o_stall  = i_id_valid & ~i_flush & (|w_lu);
   assign ex_vld_d = i_id_valid & i_id_wr & ~o_stall & ~i_flush;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ex_vld_q  <= 1'b0;
         ex_rd_q   <= '0;
         ex_ld_q   <= 1'b0;
         mem_vld_q <= 1'b0;
         mem_rd_q  <= '0;
         mem_ld_q  <= 1'b0;
         wb_vld_q  <= 1'b0;
         wb_rd_q   <= '0;
      end else begin
         ex_vld_q  <= ex_vld_d;
         ex_rd_q   <= i_id_rd;
         ex_ld_q   <= i_id_load & ex_vld_d;
         mem_vld_q <= ex_vld_q;
         mem_rd_q  <= ex_rd_q;
         mem_ld_q  <= ex_ld_q;
         wb_vld_q  <= mem_vld_q;
         wb_rd_q   <= mem_rd_q;
      end
   end

`ifdef FWD_STATS_EN
   logic        w_any_fwd;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] fwd_cnt_q,   fwd_cnt_d;

   assign w_any_fwd   = |o_sel;
   assign stall_cnt_d = stall_cnt_q + {31'd0, o_stall};
   assign fwd_cnt_d   = fwd_cnt_q + {31'd0, w_any_fwd};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign o_stall_cnt = stall_cnt_q;
   assign o_fwd_cnt   = fwd_cnt_q;
`else
   logic w_unused;
   assign w_unused = mem_ld_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
// Testbench for fwd_hazard_unit: directed vector table, hand sequences and
// randomized traffic against an in-flight write history model.
`default_nettype none

module tb_fwd_hazard_unit;

   typedef struct {
      logic       vld, wr, ld, fl;
      logic [4:0] rd, rs0, rs1;
      logic [1:0] s0, s1;
      logic       st;
   } vec_t;

   typedef struct {
      logic       v;
      logic [4:0] rd;
      logic       ld;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_wr, id_load, flush;
   logic [4:0]  id_rd, rs0, rs1;
   logic [9:0]  id_rs;
   logic [63:0] regbnk;
   logic [31:0] alu, mem, wb;
   logic [3:0]  sel;
   logic [63:0] fwd;
   logic        stall;
`ifdef FWD_STATS_EN
   logic [31:0] stall_cnt, fwd_cnt;
`endif

   int          n_vec = 0;
   int          n_err = 0;
   ent_t        hist [3];            // [0] = youngest (EX), [2] = oldest (WB)
   int unsigned m_stall_cnt, m_fwd_cnt;
   vec_t        tbl [20];

   assign id_rs = {rs1, rs0};

   always #5 clk = ~clk;

   fwd_hazard_unit dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_id_valid (id_valid),
      .i_id_rd    (id_rd),
      .i_id_wr    (id_wr),
      .i_id_load  (id_load),
      .i_id_rs    (id_rs),
      .i_regbnk   (regbnk),
      .i_alu_data (alu),
      .i_mem_data (mem),
      .i_wb_data  (wb),
      .i_flush    (flush),
      .o_sel      (sel),
      .o_fwd_data (fwd),
`ifdef FWD_STATS_EN
      .o_stall_cnt(stall_cnt),
      .o_fwd_cnt  (fwd_cnt),
`endif
      .o_stall    (stall)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic vld, input logic wr, input logic ld,
                               input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b,
                               input logic fl, input logic [1:0] s0, input logic [1:0] s1,
                               input logic st);
      vec_t v;
      v.vld = vld; v.wr = wr; v.ld = ld; v.rd = rd; v.rs0 = a; v.rs1 = b;
      v.fl = fl; v.s0 = s0; v.s1 = s1; v.st = st;
      return v;
   endfunction

   function automatic logic [31:0] exp_data(input logic [1:0] s, input int p);
      case (s)
         2'd0:    return (p == 0) ? regbnk[31:0] : regbnk[63:32];
         2'd1:    return alu;
         2'd2:    return mem;
         default: return wb;
      endcase
   endfunction

   // Youngest matching producer by age; a load one stage old is not ready yet.
   task automatic model_eval(output logic [1:0] s0, output logic [1:0] s1, output logic st);
      logic [4:0] rs;
      logic [1:0] s;
      logic       lu;
      bit         found;
      lu = 1'b0;
      s0 = 2'd0;
      s1 = 2'd0;
      for (int p = 0; p < 2; p++) begin
         rs    = (p == 0) ? rs0 : rs1;
         s     = 2'd0;
         found = 0;
         for (int a = 0; a < 3; a++) begin
            if (!found && hist[a].v && hist[a].rd == rs && rs != 5'd0) begin
               found = 1;
               if (a == 0 && hist[a].ld) lu = 1'b1;
               else s = 2'(a + 1);
            end
         end
         if (p == 0) s0 = s; else s1 = s;
      end
      st = id_valid && !flush && lu;
   endtask

   task automatic model_clear();
      for (int a = 0; a < 3; a++) hist[a] = '{v: 1'b0, rd: 5'd0, ld: 1'b0};
      m_stall_cnt = 0;
      m_fwd_cnt   = 0;
   endtask

   task automatic apply(input vec_t v);
      id_valid = v.vld; id_wr = v.wr; id_load = v.ld; id_rd = v.rd;
      rs0 = v.rs0; rs1 = v.rs1; flush = v.fl;
   endtask

   // Entered just after a rising edge: check mid-cycle, then advance one clock.
   task automatic cycle(input bit use_tbl, input vec_t v, input string tag);
      logic [1:0] m0, m1, e0, e1;
      logic       mst, est;
      #4;
      model_eval(m0, m1, mst);
      if (use_tbl) begin e0 = v.s0; e1 = v.s1; est = v.st; end
      else begin e0 = m0; e1 = m1; est = mst; end
      chk({tag, " sel0"},  {62'd0, sel[1:0]}, {62'd0, e0});
      chk({tag, " sel1"},  {62'd0, sel[3:2]}, {62'd0, e1});
      chk({tag, " stall"}, {63'd0, stall},    {63'd0, est});
      chk({tag, " data"},  fwd, {exp_data(e1, 1), exp_data(e0, 0)});
      @(posedge clk);
      if (rst_n) begin
         if (mst) m_stall_cnt++;
         if (m0 != 2'd0 || m1 != 2'd0) m_fwd_cnt++;
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = '{v: id_valid && id_wr && !mst && !flush, rd: id_rd, ld: id_load};
      end
      #1;
   endtask

   vec_t dummy;

   initial begin
      dummy = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[0]  = mk(1, 1, 0, 3, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 0, 0, 0, 3, 0, 0, 1, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0, 3, 0, 0, 2, 0, 0);
      tbl[3]  = mk(0, 0, 0, 0, 3, 0, 0, 3, 0, 0);
      tbl[4]  = mk(0, 0, 0, 0, 3, 3, 0, 0, 0, 0);
      tbl[5]  = mk(1, 1, 0, 4, 0, 0, 0, 0, 0, 0);
      tbl[6]  = mk(1, 1, 0, 4, 4, 0, 0, 1, 0, 0);
      tbl[7]  = mk(1, 0, 0, 0, 4, 4, 0, 1, 1, 0);
      tbl[8]  = mk(0, 0, 0, 0, 4, 0, 0, 2, 0, 0);
      tbl[9]  = mk(1, 1, 1, 5, 0, 0, 0, 0, 0, 0);
      tbl[10] = mk(1, 1, 0, 6, 5, 0, 0, 0, 0, 1);
      tbl[11] = mk(1, 1, 0, 6, 5, 0, 0, 2, 0, 0);
      tbl[12] = mk(0, 0, 0, 0, 6, 5, 0, 1, 3, 0);
      tbl[13] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[15] = mk(1, 1, 1, 7, 0, 0, 0, 0, 0, 0);
      tbl[16] = mk(1, 1, 0, 8, 7, 0, 1, 0, 0, 0);
      tbl[17] = mk(0, 0, 0, 0, 7, 8, 0, 2, 0, 0);
      tbl[18] = mk(1, 1, 1, 9, 0, 0, 0, 0, 0, 0);
      tbl[19] = mk(0, 0, 0, 0, 9, 0, 0, 0, 0, 0);

      // Reset state
      rst_n  = 1'b0;
      apply(dummy);
      rs0    = 5'd1;
      rs1    = 5'd2;
      regbnk = {32'hB, 32'hA};
      alu    = 32'h55;
      mem    = 32'h66;
      wb     = 32'h77;
      model_clear();
      #12;
      chk("reset sel",   {60'd0, sel}, 64'd0);
      chk("reset data",  fwd, {32'hB, 32'hA});
      chk("reset stall", {63'd0, stall}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         apply(tbl[i]);
         cycle(1, tbl[i], $sformatf("vec%0d", i));
      end

      // Randomized traffic with small register indices to provoke hazards
      for (int i = 0; i < 400; i++) begin
         id_valid = ($urandom_range(0, 3) != 0);
         id_wr    = ($urandom_range(0, 3) != 0);
         id_load  = ($urandom_range(0, 2) == 0);
         id_rd    = 5'($urandom_range(0, 7));
         rs0      = 5'($urandom_range(0, 7));
         rs1      = 5'($urandom_range(0, 7));
         flush    = ($urandom_range(0, 7) == 0);
         regbnk   = {$urandom, $urandom};
         alu      = $urandom;
         mem      = $urandom;
         wb       = $urandom;
         cycle(0, dummy, $sformatf("rnd%0d", i));
      end
`ifdef FWD_STATS_EN
      chk("rnd stall_cnt", {32'd0, stall_cnt}, {32'd0, m_stall_cnt});
      chk("rnd fwd_cnt",   {32'd0, fwd_cnt},   {32'd0, m_fwd_cnt});
`endif

      // Asynchronous reset in the middle of a cycle with writes in flight
      apply(mk(1, 1, 0, 10, 0, 0, 0, 0, 0, 0));
      cycle(0, dummy, "pre-rst");
      apply(mk(1, 1, 0, 11, 10, 0, 0, 0, 0, 0));
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      chk("midrst sel",   {60'd0, sel}, 64'd0);
      chk("midrst stall", {63'd0, stall}, 64'd0);
      chk("midrst data",  fwd, regbnk);
`ifdef FWD_STATS_EN
      chk("midrst stall_cnt", {32'd0, stall_cnt}, 64'd0);
      chk("midrst fwd_cnt",   {32'd0, fwd_cnt},   64'd0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply(mk(0, 0, 0, 0, 10, 11, 0, 0, 0, 0));
      cycle(0, dummy, "post-rst");

      // Two back-to-back load-use sequences
      for (int k = 0; k < 2; k++) begin
         apply(mk(1, 1, 1, 5, 0, 0, 0, 0, 0, 0));
         cycle(0, dummy, $sformatf("lw%0d", k));
         apply(mk(1, 1, 0, 6, 5, 0, 0, 0, 0, 1));
         cycle(1, mk(1, 1, 0, 6, 5, 0, 0, 0, 0, 1), $sformatf("lu-stall%0d", k));
         cycle(1, mk(1, 1, 0, 6, 5, 0, 0, 2, 0, 0), $sformatf("lu-mem%0d", k));
      end
`ifdef FWD_STATS_EN
      chk("lu stall_cnt", {32'd0, stall_cnt}, 64'd2);
      chk("lu fwd_cnt",   {32'd0, fwd_cnt},   {32'd0, m_fwd_cnt});
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
